pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the word address of the first instruction fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 stall  input  1  decode cannot accept; hold current instruction.
REQ-005 halt  input  1  decode has a halt instruction at pc_d; stop fetching.
REQ-006 redirect  input  1  execute resolved taken branch/jump; refetch from redirect_pc.
REQ-007 redirect_pc  input  32  word address of redirect target.
REQ-008 fetch_addr  output  32  combinational next-PC, driven to instruction fetch as its pc input; the memory uses bits [10:0], synchronous read.
REQ-009 pc_d  output  32  registered word address of the instruction now on the fetch stage's inst output.
REQ-010 inst_valid  output  1  registered; instruction at pc_d is valid for decode.
REQ-011 halted  output  1  registered; high in HALTED state.
REQ-012 fetch_count  output  32  registered count of valid instructions delivered to decode.

Function
REQ-013 PC is word-addressed; sequential next address is pc_d + 1, modulo 2^32.
REQ-014 The FSM SHALL have states BOOT, RUN, HALTED, 2-bit encoding.
REQ-015 fetch_addr mux priority: reset or BOOT -> RESET_PC; HALTED -> pc_d; redirect -> redirect_pc; stall -> pc_d; halt with inst_valid -> pc_d; otherwise pc_d + 1.
REQ-016 Each edge, pc_d <= fetch_addr, so the instruction presented one cycle later matches pc_d (one-cycle memory latency, zero-bubble sequential fetch).
REQ-017 BOOT: inst_valid <= 1, state -> RUN; one bubble cycle after reset release.
REQ-018 RUN, redirect=1: inst_valid <= 1, pc_d <= redirect_pc; the instruction at the old pc_d is squashed and not counted; redirect overrides stall and halt in the same cycle.
REQ-019 RUN, stall=1, redirect=0: pc_d, inst_valid, fetch_count hold; fetch_addr = pc_d keeps the memory output stable.
REQ-020 RUN, halt=1, inst_valid=1, stall=0, redirect=0: state -> HALTED, inst_valid <= 0, halted <= 1; the halt instruction is counted.
REQ-021 halt with inst_valid=0 or stall=1 SHALL be ignored.
REQ-022 HALTED: all registers hold, inst_valid=0; only reset exits.
REQ-023 fetch_count increments by 1 on each edge where inst_valid=1, stall=0, redirect=0 (instruction consumed by decode); saturates at 32'hFFFF_FFFF.
REQ-024 pc_d wraps 32'hFFFF_FFFF -> 0 without error; fetch_addr[10:0] wraps 2047 -> 0 naturally.
REQ-025 stall, halt and redirect are ignored in BOOT.

Reset
REQ-026 On an edge with rst_n=0: state <= BOOT, pc_d <= RESET_PC, inst_valid <= 0, halted <= 0, fetch_count <= 0; fetch_addr = RESET_PC combinationally while rst_n=0.
REQ-027 Reset asserted mid-stall, mid-redirect or in HALTED overrides all other inputs on that edge.

Verification
REQ-028 Reset with RESET_PC=0, idle inputs 5 cycles -> pc_d 0,0,1,2,3; inst_valid 0,1,1,1,1; fetch_count 3 at cycle 5.
REQ-029 RUN at pc_d=5, stall 3 cycles -> pc_d=5, fetch_addr=5, inst_valid=1, fetch_count frozen; release -> pc_d=6 next cycle.
REQ-030 pc_d=8, redirect=1, redirect_pc=40, stall=1, halt=1 same cycle -> next cycle pc_d=40, inst_valid=1, state RUN, fetch_count unchanged.
REQ-031 pc_d=12 valid, halt=1 -> halted=1, inst_valid=0, pc_d stays 12, fetch_count +1; later redirect=1 ignored; rst_n=0 -> BOOT, pc_d=RESET_PC.
REQ-032 RUN at pc_d=32'hFFFF_FFFE -> next pc_d FFFF_FFFF then 0, fetch_addr[10:0] 2046, 2047, 0; inst_valid stays 1.
REQ-033 fetch_count forced near saturation (FFFF_FFFE) with 3 consumed instructions -> FFFF_FFFF, holds.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program counter generator: boot, sequential fetch, redirect,
// stall hold, halt and a saturating count of delivered instructions.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_addr,
  output logic [31:0] pc_d,
  output logic        inst_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;
  logic   consume;
  logic   do_halt;

  assign consume = (state == RUN) && inst_valid
                 && !stall && !redirect;
  assign do_halt = consume && halt;

  // Holding fetch_addr at pc_d keeps the sync-read memory output stable.
  always_comb begin
    fetch_addr = pc_d + 32'd1;
    if (!rst_n || state == BOOT)
      fetch_addr = RESET_PC;
    else if (state == HALTED)
      fetch_addr = pc_d;
    else if (redirect)
      fetch_addr = redirect_pc;
    else if (stall)
      fetch_addr = pc_d;
    else if (halt && inst_valid)
      fetch_addr = pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_d        <= RESET_PC;
      inst_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      pc_d <= fetch_addr;
      unique case (state)
        BOOT: begin
          inst_valid <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (redirect) begin
            inst_valid <= 1'b1;
          end else if (do_halt) begin
            inst_valid <= 1'b0;
            halted     <= 1'b1;
            state      <= HALTED;
          end
        end
        HALTED: begin
          inst_valid <= 1'b0;
        end
        default: begin
          state      <= BOOT;
          inst_valid <= 1'b0;
        end
      endcase
      if (consume && fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: constant vector table, directed corner sequences,
// and random traffic against a reference model of the fetch rules.
module tb_pc_gen;

  localparam logic [31:0] RP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_addr;
  logic [31:0] pc_d;
  logic        inst_valid;
  logic        halted;
  logic [31:0] fetch_count;

  pc_gen #(.RESET_PC(RP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .halt(halt),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .fetch_addr(fetch_addr),
    .pc_d(pc_d),
    .inst_valid(inst_valid),
    .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  bit          m_boot;
  bit          m_halt;
  bit          m_iv;
  logic [31:0] m_pc;
  longint      m_cnt;
  logic [31:0] fa_seen;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_fa(bit r, bit s, bit h, bit d,
                                         logic [31:0] rpc);
    if (!r || m_boot) return RP;
    if (m_halt) return m_pc;
    if (d) return rpc;
    if (s) return m_pc;
    if (h && m_iv) return m_pc;
    return m_pc + 32'd1;
  endfunction

  task automatic model_edge(bit r, bit s, bit h, bit d,
                            logic [31:0] rpc);
    if (!r) begin
      m_boot = 1; m_halt = 0; m_iv = 0; m_pc = RP; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 0; m_iv = 1; m_pc = RP;
    end else if (!m_halt) begin
      if (m_iv && !s && !d && m_cnt < 64'hFFFF_FFFF)
        m_cnt = m_cnt + 1;
      if (d) begin
        m_pc = rpc; m_iv = 1;
      end else if (s) begin
        m_pc = m_pc;
      end else if (h && m_iv) begin
        m_halt = 1; m_iv = 0;
      end else begin
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  // Called at a negedge: drive, check comb path, clock, check registers.
  task automatic apply(bit r, bit s, bit h, bit d, logic [31:0] rpc);
    rst_n = r; stall = s; halt = h; redirect = d; redirect_pc = rpc;
    #1;
    fa_seen = fetch_addr;
    chk("fetch_addr", fetch_addr, exp_fa(r, s, h, d, rpc));
    @(posedge clk);
    model_edge(r, s, h, d, rpc);
    @(negedge clk);
    chk("pc_d", pc_d, m_pc);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_iv});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("fetch_count", fetch_count, m_cnt[31:0]);
  endtask

  typedef struct {
    bit          r, s, h, d;
    logic [31:0] rpc;
    logic [31:0] pc;
    bit          iv, hl;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    rst_n = 0; stall = 0; halt = 0; redirect = 0; redirect_pc = 0;
    m_boot = 1; m_halt = 0; m_iv = 0; m_pc = RP; m_cnt = 0;

    tbl[0]  = '{0,0,0,0,  0,   0,0,0,0};
    tbl[1]  = '{0,0,0,0,  0,   0,0,0,0};
    tbl[2]  = '{1,0,0,0,  0,   0,1,0,0};
    tbl[3]  = '{1,0,0,0,  0,   1,1,0,1};
    tbl[4]  = '{1,0,0,0,  0,   2,1,0,2};
    tbl[5]  = '{1,0,0,0,  0,   3,1,0,3};
    tbl[6]  = '{1,1,0,0,  0,   3,1,0,3};
    tbl[7]  = '{1,0,0,0,  0,   4,1,0,4};
    tbl[8]  = '{1,1,1,1,  100, 100,1,0,4};
    tbl[9]  = '{1,0,0,0,  0,   101,1,0,5};
    tbl[10] = '{1,0,1,0,  0,   101,0,1,6};
    tbl[11] = '{1,0,0,1,  7,   101,0,1,6};
    tbl[12] = '{0,0,0,0,  0,   0,0,0,0};
    tbl[13] = '{1,1,1,1,  55,  0,1,0,0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].d, tbl[i].rpc);
      chk($sformatf("tbl%0d_pc", i), pc_d, tbl[i].pc);
      chk($sformatf("tbl%0d_iv", i), {31'd0, inst_valid},
          {31'd0, tbl[i].iv});
      chk($sformatf("tbl%0d_halted", i), {31'd0, halted},
          {31'd0, tbl[i].hl});
      chk($sformatf("tbl%0d_cnt", i), fetch_count, tbl[i].cnt);
    end

    // stall three cycles at pc 5
    apply(1, 0, 0, 1, 5);
    begin
      logic [31:0] c0;
      c0 = fetch_count;
      for (int i = 0; i < 3; i++) begin
        apply(1, 1, 0, 0, 0);
        chk("stall_fa", fa_seen, 32'd5);
        chk("stall_pc", pc_d, 32'd5);
        chk("stall_cnt", fetch_count, c0);
      end
    end
    apply(1, 0, 0, 0, 0);
    chk("stall_release_pc", pc_d, 32'd6);

    // redirect beats stall and halt at pc 8
    apply(1, 0, 0, 1, 8);
    begin
      logic [31:0] c0;
      c0 = fetch_count;
      apply(1, 1, 1, 1, 40);
      chk("redir_pc", pc_d, 32'd40);
      chk("redir_iv", {31'd0, inst_valid}, 32'd1);
      chk("redir_halted", {31'd0, halted}, 32'd0);
      chk("redir_cnt", fetch_count, c0);
    end

    // halt at pc 12, then redirect ignored, then reset
    apply(1, 0, 0, 1, 12);
    begin
      logic [31:0] c0;
      c0 = fetch_count;
      apply(1, 0, 1, 0, 0);
      chk("halt_pc", pc_d, 32'd12);
      chk("halt_cnt", fetch_count, c0 + 32'd1);
      apply(1, 0, 0, 1, 99);
      chk("halted_redir_pc", pc_d, 32'd12);
      chk("halted_fa", fa_seen, 32'd12);
    end
    apply(0, 0, 0, 1, 99);
    chk("halt_reset_pc", pc_d, RP);
    chk("halt_reset_fa", fa_seen, RP);
    apply(1, 0, 0, 0, 0);

    // 32-bit and 11-bit address wrap
    apply(1, 0, 0, 1, 32'hFFFF_FFFE);
    apply(1, 0, 0, 0, 0);
    chk("wrap_fa_a", {21'd0, fa_seen[10:0]}, 32'd2047);
    chk("wrap_pc_a", pc_d, 32'hFFFF_FFFF);
    apply(1, 0, 0, 0, 0);
    chk("wrap_fa_b", {21'd0, fa_seen[10:0]}, 32'd0);
    chk("wrap_pc_b", pc_d, 32'd0);
    chk("wrap_iv", {31'd0, inst_valid}, 32'd1);

    // counter saturation
    apply(1, 1, 0, 0, 0);
    force dut.fetch_count = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_count;
    m_cnt = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 0, 0);
    chk("sat_cnt", fetch_count, 32'hFFFF_FFFF);
    apply(1, 0, 0, 0, 0);
    chk("sat_hold", fetch_count, 32'hFFFF_FFFF);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit r, s, h, d;
      logic [31:0] rpc;
      r = ($urandom_range(99) >= 3);
      s = ($urandom_range(99) < 25);
      h = ($urandom_range(99) < 5);
      d = ($urandom_range(99) < 15);
      rpc = $urandom;
      if ($urandom_range(1) == 1) rpc[10:0] = 11'h7FD;
      apply(r, s, h, d, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
